// File: rtl/clk_div_bank_pkg.sv
// Shared constants, width helper and per-channel action encoding for the clock divider bank.
package clk_div_bank_pkg;

    localparam int NCH_DEF         = 4;
    localparam int NBITS_DEF       = 8;
    localparam int DEFAULT_DIV_DEF = 3;

    // Channel-select width; a single channel still gets a one-bit select port.
    function automatic int chw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        ACT_SYNC  = 2'd0,
        ACT_IDLE  = 2'd1,
        ACT_TERM  = 2'd2,
        ACT_COUNT = 2'd3
    } chan_act_e;

endpackage

// File: rtl/clk_div_bank_chan.sv
// One divider channel: counter, active/shadow divisor pair, tick pulse and square wave.
module clk_div_bank_chan
    import clk_div_bank_pkg::*;
#(
    parameter int NBITS       = NBITS_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [NBITS-1:0] i_wr_div,
    output logic             o_tick,
    output logic             o_clk,
    output logic             o_pending
);

    logic [NBITS-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0] div_act_q, div_act_d;
    logic [NBITS-1:0] div_shd_q, div_shd_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;
    logic             pend_q, pend_d;
    logic [NBITS-1:0] commit_div_s;
    chan_act_e        act_s;

    // A write in the same cycle as a commit point takes precedence over the shadow.
    assign commit_div_s = i_wr ? i_wr_div : div_shd_q;

    // Select this cycle's action in priority order.
    always_comb begin
        act_s = ACT_COUNT;
        if (i_sync) begin
            act_s = ACT_SYNC;
        end else if (!i_en) begin
            act_s = ACT_IDLE;
        end else if (cnt_q == div_act_q) begin
            act_s = ACT_TERM;
        end else begin
            act_s = ACT_COUNT;
        end
    end

    // Next-state logic; the active divisor only changes at period boundaries.
    always_comb begin
        cnt_d     = cnt_q;
        div_act_d = div_act_q;
        div_shd_d = div_shd_q;
        tick_d    = 1'b0;
        clk_d     = clk_q;
        pend_d    = pend_q;
        case (act_s)
            ACT_TERM: begin
                cnt_d     = '0;
                tick_d    = 1'b1;
                clk_d     = ~clk_q;
                div_act_d = commit_div_s;
                div_shd_d = commit_div_s;
                pend_d    = 1'b0;
            end
            ACT_COUNT: begin
                cnt_d = cnt_q + NBITS'(1);
                if (i_wr) begin
                    div_shd_d = i_wr_div;
                    pend_d    = 1'b1;
                end else begin
                    div_shd_d = div_shd_q;
                    pend_d    = pend_q;
                end
            end
            default: begin
                cnt_d     = '0;
                clk_d     = 1'b0;
                div_act_d = commit_div_s;
                div_shd_d = commit_div_s;
                pend_d    = 1'b0;
            end
        endcase
    end

    // State register with asynchronous reset to the default divisor.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q     <= '0;
            div_act_q <= NBITS'(DEFAULT_DIV);
            div_shd_q <= NBITS'(DEFAULT_DIV);
            tick_q    <= 1'b0;
            clk_q     <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_act_q <= div_act_d;
            div_shd_q <= div_shd_d;
            tick_q    <= tick_d;
            clk_q     <= clk_d;
            pend_q    <= pend_d;
        end
    end

    assign o_tick    = tick_q;
    assign o_clk     = clk_q;
    assign o_pending = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH programmable clock dividers sharing a write port and a global phase resync.
module clk_div_bank
    import clk_div_bank_pkg::*;
#(
    parameter int NCH         = NCH_DEF,
    parameter int NBITS       = NBITS_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int CHW        = chw(NCH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [NCH-1:0]   i_en,
    input  logic             i_sync,
    input  logic             i_wr_en,
    input  logic [CHW-1:0]   i_wr_ch,
    input  logic [NBITS-1:0] i_wr_div,
    output logic [NCH-1:0]   o_tick,
    output logic [NCH-1:0]   o_clk,
    output logic [NCH-1:0]   o_pending
);

    logic [NCH-1:0] wr_s;

    // Channel numbers at or above NCH match no strobe, so such writes are dropped.
    always_comb begin
        wr_s = '0;
        for (int c = 0; c < NCH; c++) begin
            if (i_wr_en && (i_wr_ch == CHW'(c))) begin
                wr_s[c] = 1'b1;
            end else begin
                wr_s[c] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_div_bank_chan #(
            .NBITS       (NBITS),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_en      (i_en[g]),
            .i_sync    (i_sync),
            .i_wr      (wr_s[g]),
            .i_wr_div  (i_wr_div),
            .o_tick    (o_tick[g]),
            .o_clk     (o_clk[g]),
            .o_pending (o_pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed, table-driven bench for clk_div_bank (NCH=4, NBITS=8, DEFAULT_DIV=3).
module tb_clk_div_bank;

    logic       clk;
    logic       rst;
    logic [3:0] en;
    logic       sync;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_div;
    logic [3:0] tick;
    logic [3:0] oclk;
    logic [3:0] pend;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] en;
        logic       sync;
        logic       wr_en;
        logic [1:0] wr_ch;
        logic [7:0] wr_div;
        logic [3:0] exp_tick;
        logic [3:0] exp_clk;
        logic [3:0] exp_pend;
    } vec_t;

    vec_t vecs [20];

    clk_div_bank #(
        .NCH         (4),
        .NBITS       (8),
        .DEFAULT_DIV (3)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_sync    (sync),
        .i_wr_en   (wr_en),
        .i_wr_ch   (wr_ch),
        .i_wr_div  (wr_div),
        .o_tick    (tick),
        .o_clk     (oclk),
        .o_pending (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [3:0] e, input logic s, input logic w,
                       input logic [1:0] ch, input logic [7:0] d);
        en     = e;
        sync   = s;
        wr_en  = w;
        wr_ch  = ch;
        wr_div = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en     = 4'h0;
        sync   = 1'b0;
        wr_en  = 1'b0;
        wr_ch  = 2'd0;
        wr_div = 8'd0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // all enabled at div 3; ch1 rewritten to 5 at cnt=1 (row 6)
        vecs[0]  = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0};
        vecs[1]  = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0};
        vecs[2]  = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0};
        vecs[3]  = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 4'hF, 4'hF, 4'h0};
        vecs[4]  = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'hF, 4'h0};
        vecs[5]  = '{4'hF, 1'b0, 1'b1, 2'd1, 8'd5, 4'h0, 4'hF, 4'h2};
        vecs[6]  = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'hF, 4'h2};
        vecs[7]  = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 4'h0};
        vecs[8]  = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0};
        vecs[9]  = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0};
        vecs[10] = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0};
        vecs[11] = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 4'hD, 4'hD, 4'h0};
        vecs[12] = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'hD, 4'h0};
        vecs[13] = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 4'h2, 4'hF, 4'h0};
        vecs[14] = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'hF, 4'h0};
        vecs[15] = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 4'hD, 4'h2, 4'h0};
        vecs[16] = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h2, 4'h0};
        vecs[17] = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h2, 4'h0};
        vecs[18] = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h2, 4'h0};
        vecs[19] = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 4'hF, 4'hD, 4'h0};

        do_reset();
        chk("reset_tick", tick, 4'h0);
        chk("reset_clk", oclk, 4'h0);
        chk("reset_pend", pend, 4'h0);

        for (int i = 0; i < 20; i++) begin
            cyc(vecs[i].en, vecs[i].sync, vecs[i].wr_en, vecs[i].wr_ch, vecs[i].wr_div);
            chk($sformatf("vec%0d_tick", i), tick, vecs[i].exp_tick);
            chk($sformatf("vec%0d_clk", i), oclk, vecs[i].exp_clk);
            chk($sformatf("vec%0d_pend", i), pend, vecs[i].exp_pend);
        end

        // div=0 on ch0: committed while disabled, then tick stays high
        do_reset();
        cyc(4'h0, 1'b0, 1'b1, 2'd0, 8'd0);
        chk("div0_commit_pend", pend, 4'h0);
        for (int k = 1; k <= 6; k++) begin
            cyc(4'h1, 1'b0, 1'b0, 2'd0, 8'd0);
            chk($sformatf("div0_tick%0d", k), tick, 4'h1);
            chk($sformatf("div0_clk%0d", k), oclk, (k % 2 == 1) ? 4'h1 : 4'h0);
        end

        // write on ch2 exactly at the terminal cycle
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            cyc(4'hF, 1'b0, (k == 4), 2'd2, 8'd1);
            chk($sformatf("termwr_pend%0d", k), pend, 4'h0);
            chk($sformatf("termwr_tick2_%0d", k), {3'b000, tick[2]},
                {3'b000, (k == 4 || k == 6 || k == 8)});
        end

        // ch2 disabled at cnt=2, re-enabled later
        do_reset();
        cyc(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
        cyc(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
        for (int k = 3; k <= 10; k++) begin
            cyc((k <= 6) ? 4'hB : 4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
            chk($sformatf("endrop_tick2_%0d", k), {3'b000, tick[2]}, {3'b000, (k == 10)});
        end

        // largest divisor: 256-cycle period without overflow
        do_reset();
        cyc(4'h0, 1'b0, 1'b1, 2'd3, 8'd255);
        for (int k = 1; k <= 256; k++) begin
            cyc(4'h8, 1'b0, 1'b0, 2'd0, 8'd0);
            if (tick[3] !== (k == 256)) begin
                chk($sformatf("maxdiv_tick%0d", k), tick, (k == 256) ? 4'h8 : 4'h0);
            end
        end
        chk("maxdiv_final_tick", tick, 4'h8);

        // divisors 2,3,4,3 free-running, then sync realigns
        do_reset();
        cyc(4'h0, 1'b0, 1'b1, 2'd0, 8'd2);
        cyc(4'h0, 1'b0, 1'b1, 2'd2, 8'd4);
        for (int k = 0; k < 7; k++) begin
            cyc(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
        end
        cyc(4'hF, 1'b1, 1'b0, 2'd0, 8'd0);
        chk("sync_tick", tick, 4'h0);
        chk("sync_clk", oclk, 4'h0);
        chk("sync_pend", pend, 4'h0);
        for (int k = 1; k <= 5; k++) begin
            logic [3:0] et;
            logic [3:0] ec;
            cyc(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
            et = {(k == 4), (k == 5), (k == 4), (k == 3)};
            ec = {(k >= 4), (k >= 5), (k >= 4), (k >= 3)};
            chk($sformatf("resync_tick%0d", k), tick, et);
            chk($sformatf("resync_clk%0d", k), oclk, ec);
        end

        // async reset mid-period clears outputs without a clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_clk", oclk, 4'h0);
        chk("async_rst_tick", tick, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
            chk($sformatf("postrst_tick%0d", k), tick, (k == 4) ? 4'hF : 4'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
